// File: rtl/pl_reg_sequencer.sv
// AXI4-Lite register sequencer: writes C_BASE_DATA+i to C_NUM_REGS consecutive words, then optionally
// reads them back and counts mismatches. Readback is enabled by defining PL_REG_SEQ_READBACK_EN.
module pl_reg_sequencer #(
    parameter int          C_NUM_REGS         = 4,
    parameter int          C_M_AXI_ADDR_WIDTH = 4,
    parameter logic [31:0] C_BASE_DATA        = 32'h00000001
) (
    input  logic                          ACLK,
    input  logic                          ARESETN,
    input  logic                          start,
    output logic                          busy,
    output logic                          done,
    output logic                          pass,
    output logic [7:0]                    err_cnt,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_AWADDR,
    output logic [2:0]                    M_AXI_AWPROT,
    output logic                          M_AXI_AWVALID,
    input  logic                          M_AXI_AWREADY,
    output logic [31:0]                   M_AXI_WDATA,
    output logic [3:0]                    M_AXI_WSTRB,
    output logic                          M_AXI_WVALID,
    input  logic                          M_AXI_WREADY,
    input  logic [1:0]                    M_AXI_BRESP,
    input  logic                          M_AXI_BVALID,
    output logic                          M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
    output logic [2:0]                    M_AXI_ARPROT,
    output logic                          M_AXI_ARVALID,
    input  logic                          M_AXI_ARREADY,
    input  logic [31:0]                   M_AXI_RDATA,
    input  logic [1:0]                    M_AXI_RRESP,
    input  logic                          M_AXI_RVALID,
    output logic                          M_AXI_RREADY
);

    typedef enum logic [2:0] {
        S_IDLE, S_WR_REQ, S_WR_RESP, S_RD_REQ, S_RD_RESP, S_FIN
    } state_t;

    localparam logic [3:0] LAST_IDX = 4'(C_NUM_REGS - 1);

    function automatic logic [C_M_AXI_ADDR_WIDTH-1:0] reg_addr(input logic [3:0] idx);
        logic [31:0] byte_addr;
        byte_addr = {26'd0, idx, 2'b00};
        return byte_addr[C_M_AXI_ADDR_WIDTH-1:0];
    endfunction

    function automatic logic [31:0] reg_data(input logic [3:0] idx);
        return C_BASE_DATA + {28'd0, idx};
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    state_t                          state_q;
    logic [3:0]                      idx_q;
    logic                            awvalid_q, wvalid_q, bready_q;
    logic                            busy_q, done_q, pass_q;
    logic [7:0]                      err_q;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   awaddr_q;
    logic [31:0]                     wdata_q;

    logic                            last_d;
    logic                            wr_ld_d;
    logic [3:0]                      ld_idx_d;
    logic                            aw_ok_d, w_ok_d;

    assign last_d  = (idx_q == LAST_IDX);
    // A channel is finished once its VALID has dropped or is being accepted this cycle.
    assign aw_ok_d = !awvalid_q || M_AXI_AWREADY;
    assign w_ok_d  = !wvalid_q || M_AXI_WREADY;

`ifdef PL_REG_SEQ_READBACK_EN
    logic                            arvalid_q, rready_q;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   araddr_q;
    logic                            rd_ld_d;
    logic                            rd_err_d;

    assign rd_err_d = (M_AXI_RRESP != 2'b00) || (M_AXI_RDATA != reg_data(idx_q));
`endif

    always_comb begin
        wr_ld_d  = 1'b0;
        ld_idx_d = idx_q + 4'd1;
`ifdef PL_REG_SEQ_READBACK_EN
        rd_ld_d  = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    wr_ld_d  = 1'b1;
                    ld_idx_d = '0;
                end
            end
            S_WR_RESP: begin
                if (M_AXI_BVALID) begin
                    wr_ld_d = !last_d;
`ifdef PL_REG_SEQ_READBACK_EN
                    rd_ld_d = last_d;
                    if (last_d) ld_idx_d = '0;
`endif
                end
            end
`ifdef PL_REG_SEQ_READBACK_EN
            S_RD_RESP: begin
                if (M_AXI_RVALID && !last_d) rd_ld_d = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    // Address/data hold registers: only loaded when a new request is launched.
    always_ff @(posedge ACLK) begin
        if (wr_ld_d) begin
            awaddr_q <= reg_addr(ld_idx_d);
            wdata_q  <= reg_data(ld_idx_d);
        end
`ifdef PL_REG_SEQ_READBACK_EN
        if (rd_ld_d) araddr_q <= reg_addr(ld_idx_d);
`endif
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            err_q     <= '0;
`ifdef PL_REG_SEQ_READBACK_EN
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            if (wr_ld_d) begin
                awvalid_q <= 1'b1;
                wvalid_q  <= 1'b1;
                idx_q     <= ld_idx_d;
            end
`ifdef PL_REG_SEQ_READBACK_EN
            if (rd_ld_d) begin
                arvalid_q <= 1'b1;
                idx_q     <= ld_idx_d;
            end
`endif
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_WR_REQ;
                        busy_q  <= 1'b1;
                        err_q   <= '0;
                    end
                end
                S_WR_REQ: begin
                    if (M_AXI_AWREADY) awvalid_q <= 1'b0;
                    if (M_AXI_WREADY)  wvalid_q  <= 1'b0;
                    if (aw_ok_d && w_ok_d) begin
                        state_q  <= S_WR_RESP;
                        bready_q <= 1'b1;
                    end
                end
                S_WR_RESP: begin
                    if (M_AXI_BVALID) begin
                        bready_q <= 1'b0;
                        if (M_AXI_BRESP != 2'b00) err_q <= sat_inc(err_q);
                        if (!last_d) state_q <= S_WR_REQ;
`ifdef PL_REG_SEQ_READBACK_EN
                        else state_q <= S_RD_REQ;
`else
                        else state_q <= S_FIN;
`endif
                    end
                end
`ifdef PL_REG_SEQ_READBACK_EN
                S_RD_REQ: begin
                    if (M_AXI_ARREADY) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= S_RD_RESP;
                    end
                end
                S_RD_RESP: begin
                    if (M_AXI_RVALID) begin
                        rready_q <= 1'b0;
                        if (rd_err_d) err_q <= sat_inc(err_q);
                        state_q <= last_d ? S_FIN : S_RD_REQ;
                    end
                end
`endif
                S_FIN: begin
                    done_q  <= 1'b1;
                    pass_q  <= (err_q == 8'd0);
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign err_cnt       = err_q;
    assign M_AXI_AWADDR  = awaddr_q;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = 4'hF;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_BREADY  = bready_q;
    assign M_AXI_ARPROT  = 3'b000;

`ifdef PL_REG_SEQ_READBACK_EN
    assign M_AXI_ARADDR  = araddr_q;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_RREADY  = rready_q;
`else
    logic unused_rd;
    assign unused_rd     = ^{M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID};
    assign M_AXI_ARADDR  = '0;
    assign M_AXI_ARVALID = 1'b0;
    assign M_AXI_RREADY  = 1'b0;
`endif

endmodule

// File: tb/tb_pl_reg_sequencer.sv
// Bench for pl_reg_sequencer: randomized AXI4-Lite slave plus a sequence-level reference model.
module tb_pl_reg_sequencer;
    localparam int          N    = 4;
    localparam int          AW   = 4;
    localparam logic [31:0] BASE = 32'h00000001;
`ifdef PL_REG_SEQ_READBACK_EN
    localparam bit READBACK = 1'b1;
`else
    localparam bit READBACK = 1'b0;
`endif

    logic clk, rstn, start, busy, done, pass;
    logic [7:0] err_cnt;
    logic [AW-1:0] awaddr, araddr;
    logic [2:0] awprot, arprot;
    logic awvalid, awready, wvalid, wready, bvalid, bready;
    logic arvalid, arready, rvalid, rready;
    logic [31:0] wdata, rdata;
    logic [3:0] wstrb;
    logic [1:0] bresp, rresp;

    pl_reg_sequencer #(.C_NUM_REGS(N), .C_M_AXI_ADDR_WIDTH(AW), .C_BASE_DATA(BASE)) dut (
        .ACLK(clk), .ARESETN(rstn), .start(start), .busy(busy), .done(done), .pass(pass),
        .err_cnt(err_cnt),
        .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
        .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
        .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
        .M_AXI_ARADDR(araddr), .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
        .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Slave configuration, written only by the stimulus process.
    int          aw_dly [16];
    int          w_dly  [16];
    int          b_dly, ar_dly;
    logic [15:0] bresp_mask, rresp_mask;
    bit          ov_en;
    int          ov_idx;
    logic [31:0] ov_data;
    int          seq_id = 0;

    // Slave/monitor state, written only by the slave process.
    logic [31:0] aw_q[$], w_q[$], ar_q[$];
    logic [31:0] mem [16];
    int b_done, r_done, done_cnt, arv_seen, hold_bad, strb_bad, prot_bad, last_seq;
    int aw_cnt, w_cnt, b_cnt, ar_cnt;
    logic p_awv, p_awr, p_wv, p_wr, p_bv, p_br, p_arv, p_arr, p_rv, p_rr;
    logic [AW-1:0] p_awaddr, p_araddr;
    logic [31:0] p_wdata;

    always @(negedge clk) begin
        if (seq_id != last_seq) begin
            last_seq = seq_id;
            aw_q.delete(); w_q.delete(); ar_q.delete();
            b_done = 0; r_done = 0; done_cnt = 0; arv_seen = 0;
            hold_bad = 0; strb_bad = 0; prot_bad = 0;
        end
        if (!rstn) begin
            awready = 0; wready = 0; bvalid = 0; bresp = 0; arready = 0;
            rvalid = 0; rresp = 0; rdata = 0;
            aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0;
            {p_awv, p_awr, p_wv, p_wr, p_bv, p_br, p_arv, p_arr, p_rv, p_rr} = '0;
        end else begin
            // Handshakes completed at the preceding rising edge.
            if (p_awv && p_awr) aw_q.push_back({28'd0, p_awaddr});
            if (p_wv && p_wr) w_q.push_back(p_wdata);
            if (p_bv && p_br) begin bvalid = 0; b_done++; end
            if (p_arv && p_arr) ar_q.push_back({28'd0, p_araddr});
            if (p_rv && p_rr) begin rvalid = 0; r_done++; end
            if (p_awv && !p_awr && !(awvalid && awaddr == p_awaddr)) hold_bad++;
            if (p_wv && !p_wr && !(wvalid && wdata == p_wdata)) hold_bad++;
            if (p_arv && !p_arr && !(arvalid && araddr == p_araddr)) hold_bad++;
            if (wvalid && wstrb != 4'hF) strb_bad++;
            if ((awvalid && awprot != 3'd0) || (arvalid && arprot != 3'd0)) prot_bad++;

            if (awvalid) begin awready = (aw_cnt >= aw_dly[b_done & 15]); aw_cnt++; end
            else begin awready = 0; aw_cnt = 0; end
            if (wvalid) begin wready = (w_cnt >= w_dly[b_done & 15]); w_cnt++; end
            else begin wready = 0; w_cnt = 0; end
            if (arvalid) begin arready = (ar_cnt >= ar_dly); ar_cnt++; end
            else begin arready = 0; ar_cnt = 0; end

            if (!bvalid && b_done < aw_q.size() && b_done < w_q.size()) begin
                if (b_cnt >= b_dly) begin
                    int bi;
                    bi = int'(aw_q[b_done] >> 2);
                    mem[bi] = w_q[b_done];
                    bvalid = 1;
                    bresp = bresp_mask[bi] ? 2'b10 : 2'b00;
                    b_cnt = 0;
                end else b_cnt++;
            end
            if (!rvalid && r_done < ar_q.size()) begin
                int ri;
                ri = int'(ar_q[r_done] >> 2);
                rvalid = 1;
                rdata = (ov_en && ri == ov_idx) ? ov_data : mem[ri];
                rresp = rresp_mask[ri] ? 2'b10 : 2'b00;
            end
            if (done) done_cnt++;
            if (arvalid) arv_seen++;

            p_awv = awvalid; p_awr = awready; p_awaddr = awaddr;
            p_wv = wvalid; p_wr = wready; p_wdata = wdata;
            p_bv = bvalid; p_br = bready;
            p_arv = arvalid; p_arr = arready; p_araddr = araddr;
            p_rv = rvalid; p_rr = rready;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Reference model: one error per bad B response, plus one per bad read beat when reading back.
    function automatic int model_errs();
        int e;
        e = 0;
        for (int i = 0; i < N; i++) begin
            if (bresp_mask[i]) e++;
            if (READBACK && (rresp_mask[i] || (ov_en && ov_idx == i && ov_data != BASE + 32'(i)))) e++;
        end
        return (e > 255) ? 255 : e;
    endfunction

    task automatic set_delays(input int awd, input int wd);
        for (int i = 0; i < 16; i++) begin aw_dly[i] = awd; w_dly[i] = wd; end
    endtask

    task automatic run_seq(input string tag, input int extra_starts);
        int cyc, e;
        e = model_errs();
        seq_id++;
        tick();
        start = 1; tick(); start = 0;
        chk({tag, ":busy_after_start"}, busy, 1);
        for (int k = 0; k < extra_starts; k++) begin
            tick(); start = 1; tick(); start = 0;
        end
        cyc = 0;
        while (done_cnt == 0 && cyc < 3000) begin tick(); cyc++; end
        chk({tag, ":done_seen"}, done_cnt != 0, 1);
        chk({tag, ":err_cnt"}, err_cnt, e);
        chk({tag, ":pass"}, pass, e == 0);
        chk({tag, ":busy_at_done"}, busy, 0);
        for (int k = 0; k < 12; k++) tick();
        chk({tag, ":done_pulses"}, done_cnt, 1);
        chk({tag, ":n_aw"}, aw_q.size(), N);
        chk({tag, ":n_w"}, w_q.size(), N);
        chk({tag, ":n_b"}, b_done, N);
        for (int i = 0; i < N && i < aw_q.size() && i < w_q.size(); i++) begin
            chk($sformatf("%s:awaddr%0d", tag, i), aw_q[i], 32'(4 * i));
            chk($sformatf("%s:wdata%0d", tag, i), w_q[i], BASE + 32'(i));
        end
        chk({tag, ":n_ar"}, ar_q.size(), READBACK ? N : 0);
        for (int i = 0; i < ar_q.size() && i < N; i++)
            chk($sformatf("%s:araddr%0d", tag, i), ar_q[i], 32'(4 * i));
        chk({tag, ":arvalid_seen"}, arv_seen != 0, READBACK);
        chk({tag, ":hold_viol"}, hold_bad, 0);
        chk({tag, ":strb_viol"}, strb_bad, 0);
        chk({tag, ":prot_viol"}, prot_bad, 0);
    endtask

    task automatic clean_cfg();
        set_delays(0, 0);
        b_dly = 0; ar_dly = 0; bresp_mask = '0; rresp_mask = '0;
        ov_en = 0; ov_idx = 0; ov_data = '0;
    endtask

    initial begin
        int cyc;
        rstn = 0; start = 0;
        clean_cfg();
        for (int i = 0; i < 16; i++) mem[i] = 32'hDEAD0000 + 32'(i);
        repeat (3) tick();
        chk("reset_outputs", {awvalid, wvalid, bready, arvalid, rready, busy, done, pass, err_cnt},
            16'h0000);
        rstn = 1;
        tick();
        chk("idle_busy", busy, 0);

        run_seq("basic", 0);

        clean_cfg(); ov_en = 1; ov_idx = 2; ov_data = 32'h5;
        run_seq("rd_bad_0x8", 0);

        clean_cfg(); set_delays(3, 0); run_seq("aw_late", 0);
        clean_cfg(); set_delays(0, 3); run_seq("w_late", 0);
        clean_cfg(); set_delays(2, 2); b_dly = 2; run_seq("both_same", 0);

        clean_cfg(); bresp_mask = 16'h0002;
        run_seq("bresp_reg1", 0);

        clean_cfg(); set_delays(2, 1); ar_dly = 1;
        run_seq("start_busy", 3);

        // Asynchronous reset in the middle of a write request.
        clean_cfg(); set_delays(5, 5);
        run_seq("pre_reset", 0);
        seq_id++;
        tick();
        start = 1; tick(); start = 0;
        cyc = 0;
        while (!awvalid && cyc < 50) begin tick(); cyc++; end
        chk("awvalid_before_reset", awvalid, 1);
        #2 rstn = 0;
        #1;
        chk("midreset_outputs", {awvalid, wvalid, bready, arvalid, rready, busy, done, pass, err_cnt},
            16'h0000);
        repeat (2) tick();
        rstn = 1;
        tick();
        chk("post_reset_busy", busy, 0);
        clean_cfg();
        run_seq("after_reset", 0);

        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 16; i++) begin
                aw_dly[i] = $urandom_range(0, 3);
                w_dly[i] = $urandom_range(0, 3);
            end
            b_dly = $urandom_range(0, 2);
            ar_dly = $urandom_range(0, 2);
            bresp_mask = '0; rresp_mask = '0;
            for (int i = 0; i < N; i++) begin
                bresp_mask[i] = ($urandom_range(0, 3) == 0);
                rresp_mask[i] = ($urandom_range(0, 3) == 0);
            end
            ov_en = $urandom_range(0, 1) == 1;
            ov_idx = $urandom_range(0, N - 1);
            ov_data = $urandom();
            run_seq($sformatf("rand%0d", r), $urandom_range(0, 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
